// File: rtl/pair_stuffer.sv
// pair_stuffer: byte-stuffing encoder for (a, b) operand pairs.
// Each byte equal to 8'h00 or ESC_BYTE goes out as ESC_BYTE, byte ^ XOR_MASK.
// All other bytes go out unchanged. For every pair, a is sent before b.
// Optional macro STUFF_TERM_EN: after the last pair of a frame, a raw 8'h00
// terminator beat carries out_last, instead of the final b beat carrying it.
module pair_stuffer #(
    parameter logic [7:0] ESC_BYTE = 8'h7d,
    parameter logic [7:0] XOR_MASK = 8'h20,
    parameter int         CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] pair_cnt
);

`ifdef STUFF_TERM_EN
    localparam bit TERM_EN = 1'b1;
`else
    localparam bit TERM_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        A_ESC = 3'd1,
        A_DAT = 3'd2,
        B_ESC = 3'd3,
        B_DAT = 3'd4,
        TERM  = 3'd5
    } state_t;

    state_t     state;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       last_q;

    // Bytes that collide with the terminator or the escape marker itself
    function automatic logic esc(input logic [7:0] x);
        return (x == 8'h00) || (x == ESC_BYTE);
    endfunction

    // Second beat of an escaped byte, or the byte itself when no escape is needed
    function automatic logic [7:0] stuff(input logic [7:0] x);
        return esc(x) ? (x ^ XOR_MASK) : x;
    endfunction

    // A pair is only taken while nothing is in flight
    assign in_ready = (state == IDLE);

    // Encoder FSM: each output beat is loaded when the previous beat is accepted
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
            pair_cnt  <= '0;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            last_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q       <= in_a;
                        b_q       <= in_b;
                        last_q    <= in_last;
                        pair_cnt  <= pair_cnt + 1'b1;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        if (esc(in_a)) begin
                            state    <= A_ESC;
                            out_data <= ESC_BYTE;
                        end else begin
                            state    <= A_DAT;
                            out_data <= in_a;
                        end
                    end
                end
                A_ESC: begin
                    if (out_ready) begin
                        state    <= A_DAT;
                        out_data <= stuff(a_q);
                    end
                end
                A_DAT: begin
                    if (out_ready) begin
                        if (esc(b_q)) begin
                            state    <= B_ESC;
                            out_data <= ESC_BYTE;
                        end else begin
                            state    <= B_DAT;
                            out_data <= b_q;
                            out_last <= last_q && !TERM_EN;
                        end
                    end
                end
                B_ESC: begin
                    if (out_ready) begin
                        state    <= B_DAT;
                        out_data <= stuff(b_q);
                        out_last <= last_q && !TERM_EN;
                    end
                end
                B_DAT: begin
                    if (out_ready) begin
                        if (TERM_EN && last_q) begin
                            state    <= TERM;
                            out_data <= 8'h00;
                            out_last <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_data  <= 8'h00;
                            out_last  <= 1'b0;
                        end
                    end
                end
                TERM: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_data  <= 8'h00;
                        out_last  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_data  <= 8'h00;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pair_stuffer.sv
// tb_pair_stuffer: directed bench for pair_stuffer.
// The expected behaviour depends on STUFF_TERM_EN, which must be defined the same way as for the DUT.
module tb_pair_stuffer;

`ifdef STUFF_TERM_EN
    localparam bit TB_TERM = 1'b1;
`else
    localparam bit TB_TERM = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [31:0] pair_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    bit         mon_en = 1'b0;
    bit         tog_en = 1'b0;
    logic [7:0] cap_d[$];
    bit         cap_l[$];
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    bit         exp_l[$];
    int         exp_cnt = 0;

    pair_stuffer dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .pair_cnt  (pair_cnt)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Output monitor: captures transfers and checks that stalled beats hold
    initial begin
        bit         prev_stall = 1'b0;
        logic [7:0] prev_d = 8'h00;
        bit         prev_l = 1'b0;
        forever begin
            @(negedge clk_i);
            if (mon_en) begin
                if (prev_stall)
                    chk("stall_hold", {22'b0, out_valid, out_last, out_data},
                        {22'b0, 1'b1, prev_l, prev_d});
                if (out_valid && out_ready) begin
                    cap_d.push_back(out_data);
                    cap_l.push_back(out_last);
                end
                prev_stall = out_valid && !out_ready;
                prev_d     = out_data;
                prev_l     = out_last;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // out_ready toggler for the backpressure test
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (tog_en) out_ready = ~out_ready;
        end
    end

    // Caller is at posedge+1; returns at posedge+1 right after the accepting edge
    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit l);
        int n = 0;
        in_a = a; in_b = b; in_last = l; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk_i); #1; n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk_i); #1;
        in_valid = 1'b0;
        exp_cnt++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(in_ready && !out_valid) && n < 200) begin
            @(posedge clk_i); #1; n++;
        end
        if (!(in_ready && !out_valid)) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [7:0] pick_byte();
        case ($urandom_range(0, 6))
            0: return 8'h00;
            1: return 8'h7d;
            2: return 8'h20;
            3: return 8'h5d;
            4: return 8'hff;
            default: return 8'($urandom);
        endcase
    endfunction

    // Unstuff the captured stream and compare against the queued pairs
    task automatic decode_check(input int n);
        int i = 0;
        int d = 0;
        int terms = 0;
        int lasts = 0;
        logic [7:0] v;
        bit el;
        for (int k = 0; k < n; k++) if (exp_l[k]) lasts++;
        while (i < cap_d.size()) begin
            if (cap_d[i] == 8'h00) begin
                chk("raw00", {30'b0, 1'b1, cap_l[i]}, {30'b0, TB_TERM, 1'b1});
                terms++;
                i++;
                continue;
            end
            if (cap_d[i] == 8'h7d) begin
                chk("esc_last", {31'b0, cap_l[i]}, 32'd0);
                i++;
                if (i >= cap_d.size()) begin
                    chk("esc_trunc", 32'd0, 32'd1);
                    break;
                end
                chk("esc_follow", {31'b0, (cap_d[i] == 8'h20) || (cap_d[i] == 8'h5d)}, 32'd1);
                v = cap_d[i] ^ 8'h20;
            end else begin
                v = cap_d[i];
            end
            el = !TB_TERM && (d % 2 == 1) && (d / 2 < n) && exp_l[d / 2];
            chk("data_last", {31'b0, cap_l[i]}, {31'b0, el});
            if (d / 2 < n) chk("decoded", {24'b0, v}, {24'b0, (d % 2) ? exp_b[d / 2] : exp_a[d / 2]});
            d++;
            i++;
        end
        chk("decoded_cnt", d, 2 * n);
        chk("term_cnt", terms, TB_TERM ? lasts : 0);
    endtask

    initial begin
        logic [7:0] e2_d[5];
        bit         e2_l[5];
        int         e2_n;

        reset_i = 1'b0; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00;
        in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {24'b0, out_data}, 32'd0);
        chk("rst_out_last", {31'b0, out_last}, 32'd0);
        chk("rst_pair_cnt", pair_cnt, 32'd0);
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        mon_en = 1'b1;

        // Plain pair, exact beat timing
        cap_d.delete(); cap_l.delete();
        send(8'h12, 8'h34, 1'b0);
        chk("t1_beat0_valid", {31'b0, out_valid}, 32'd1);
        chk("t1_beat0_data", {24'b0, out_data}, 32'h12);
        @(posedge clk_i); #1;
        chk("t1_beat1", {23'b0, out_valid, out_last, out_data}, {23'b0, 1'b1, 1'b0, 8'h34});
        @(posedge clk_i); #1;
        chk("t1_idle_valid", {31'b0, out_valid}, 32'd0);
        chk("t1_in_ready", {31'b0, in_ready}, 32'd1);
        chk("t1_pair_cnt", pair_cnt, 32'd1);
        chk("t1_cap_n", cap_d.size(), 2);

        // Both bytes escaped, last pair of a frame
        cap_d.delete(); cap_l.delete();
        send(8'h7d, 8'h00, 1'b1);
        wait_idle();
        e2_d[0] = 8'h7d; e2_d[1] = 8'h5d; e2_d[2] = 8'h7d; e2_d[3] = 8'h20; e2_d[4] = 8'h00;
        e2_l[0] = 1'b0;  e2_l[1] = 1'b0;  e2_l[2] = 1'b0;  e2_l[3] = !TB_TERM; e2_l[4] = 1'b1;
        e2_n = TB_TERM ? 5 : 4;
        chk("t2_cap_n", cap_d.size(), e2_n);
        for (int k = 0; k < e2_n && k < cap_d.size(); k++) begin
            chk("t2_data", {24'b0, cap_d[k]}, {24'b0, e2_d[k]});
            chk("t2_last", {31'b0, cap_l[k]}, {31'b0, e2_l[k]});
        end
        chk("t2_pair_cnt", pair_cnt, exp_cnt);

        // 100 pairs under 1010 backpressure
        cap_d.delete(); cap_l.delete();
        exp_a.delete(); exp_b.delete(); exp_l.delete();
        out_ready = 1'b1;
        tog_en = 1'b1;
        for (int k = 0; k < 100; k++) begin
            logic [7:0] a;
            logic [7:0] b;
            bit l;
            a = pick_byte();
            b = pick_byte();
            l = ($urandom_range(0, 3) == 0);
            exp_a.push_back(a); exp_b.push_back(b); exp_l.push_back(l);
            send(a, b, l);
        end
        wait_idle();
        tog_en = 1'b0;
        out_ready = 1'b1;
        decode_check(100);
        chk("t3_pair_cnt", pair_cnt, exp_cnt);

        // Asynchronous reset while an escape beat is pending
        mon_en = 1'b0;
        out_ready = 1'b0;
        send(8'h00, 8'h11, 1'b0);
        chk("t4_pre_valid", {31'b0, out_valid}, 32'd1);
        chk("t4_pre_data", {24'b0, out_data}, 32'h7d);
        #2 reset_i = 1'b0;
        #1;
        chk("t4_async_valid", {31'b0, out_valid}, 32'd0);
        chk("t4_async_data", {24'b0, out_data}, 32'd0);
        chk("t4_async_cnt", pair_cnt, 32'd0);
        chk("t4_async_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        exp_cnt = 0;
        out_ready = 1'b1;
        @(posedge clk_i); #1;
        cap_d.delete(); cap_l.delete();
        mon_en = 1'b1;
        send(8'h01, 8'h02, 1'b0);
        wait_idle();
        chk("t4_cap_n", cap_d.size(), 2);
        if (cap_d.size() >= 2) begin
            chk("t4_b0", {24'b0, cap_d[0]}, 32'h01);
            chk("t4_b1", {24'b0, cap_d[1]}, 32'h02);
        end
        chk("t4_pair_cnt", pair_cnt, 32'd1);

        // Counter wrap
        force dut.pair_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.pair_cnt;
        @(posedge clk_i); #1;
        send(8'h55, 8'h66, 1'b0);
        wait_idle();
        chk("t5_wrap", pair_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pair_stuffer.md
Name: pair_stuffer

Overview:
- Hardware byte-stuffing encoder that serialises (a, b) operand pairs into an escaped byte stream for the host link.
- Escape byte is 8'h7d. Each data byte equal to 8'h00 or 8'h7d is sent as 8'h7d followed by (byte ^ 8'h20). All other bytes are sent verbatim.
- For every pair, a is sent first, then b.
- Sits between the adder-side operand source and the byte-wide host/DPI link. It is the transmit counterpart of the host-side unstuffer, which stops parsing at a raw 8'h00.

Parameters:
- ESC_BYTE, 8'h7d, escape marker byte.
- XOR_MASK, 8'h20, mask applied to an escaped byte.
- CNT_W, 32, width of the accepted-pair counter.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  reset, asynchronous, active-low (0 = reset).
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair.
- in_a  in  8  first operand byte.
- in_b  in  8  second operand byte.
- in_last  in  1  pair is the final pair of a frame.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts out_data.
- out_data  out  8  stuffed byte stream.
- out_last  out  1  marks the final byte of a frame.
- pair_cnt  out  CNT_W  number of pairs accepted since reset.

Behaviour:
- Reset (reset_i = 0, asynchronous):
  - state = IDLE, in_ready = 1, out_valid = 0, out_data = 8'h00, out_last = 0, pair_cnt = 0.
  - Internal a/b holding registers = 0.
  - Reset mid-pair discards any partial output immediately. No remaining bytes are emitted after release.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = 1 only in IDLE (combinational from state).
  - While out_valid && !out_ready, out_data and out_last are held stable.
  - out_valid never drops without a transfer.
- Escape test per byte: esc(x) = (x == 8'h00) || (x == ESC_BYTE).
- State machine (all outputs registered):
  - IDLE: on input transfer, latch a, b, last; pair_cnt += 1. Next state is A_ESC if esc(a), else A_DAT. out_valid is asserted the cycle after the input transfer.
  - A_ESC: out_data = ESC_BYTE. On transfer, go to A_DAT.
  - A_DAT: out_data = esc(a) ? a ^ XOR_MASK : a. On transfer, go to B_ESC if esc(b), else B_DAT.
  - B_ESC: out_data = ESC_BYTE. On transfer, go to B_DAT.
  - B_DAT: out_data = esc(b) ? b ^ XOR_MASK : b. out_last = latched last, unless STUFF_TERM_EN is defined. On transfer, go to TERM if (STUFF_TERM_EN && last), else IDLE.
  - TERM: see Optional Feature.
- Latency and throughput:
  - First byte of a pair is valid 1 cycle after acceptance.
  - A pair occupies 2–4 output beats plus 1 IDLE cycle. Maximum rate is 1 pair per 3 cycles with no escapes and out_ready held at 1.
- Boundaries:
  - in_valid asserted while not in IDLE: ignored, and the source must hold it.
  - pair_cnt wraps from 2^CNT_W-1 to 0 silently.
  - a = b = 8'h7d produces 4 beats: 7d 5d 7d 5d.
  - The byte 8'h20 is never escaped. Only the encodings 7d 20 and 7d 5d appear after the escape byte.
  - out_ready low for any number of cycles stalls the FSM without loss.

Optional Feature:
- Macro: STUFF_TERM_EN.
- Defined:
  - After B_DAT of a pair with in_last = 1, state TERM emits a raw 8'h00 with out_last = 1, then returns to IDLE.
  - out_last is 0 on the B_DAT beat.
  - Since data zeros are always escaped, a raw 00 terminates the host string unambiguously.
- Undefined:
  - TERM is unreachable and no terminator is emitted.
  - out_last = 1 on the B_DAT beat of the last pair.

Test Plan:
- Reset, then pair (a=8'h12, b=8'h34, last=0) with out_ready=1 -> beats 12, 34 on consecutive cycles starting 1 cycle after accept; pair_cnt=1; in_ready returns to 1.
- Pair (8'h7d, 8'h00, last=1), TERM_EN undefined -> beats 7d 5d 7d 20; out_last=1 on 8'h20 only.
- Same pair with STUFF_TERM_EN defined -> beats 7d 5d 7d 20 00; out_last=1 only on final 00.
- out_ready toggled 1010… across 100 random pairs -> unstuffing the captured stream reproduces every pair exactly; out_data stable during every stall; pair_cnt=100.
- Assert reset_i=0 mid-escape (state A_ESC, out_valid=1) -> out_valid drops to 0 asynchronously; after release, the next pair (8'h01, 8'h02) emits only 01 02.
- Preload pair_cnt near wrap (force to 32'hFFFF_FFFF), accept one pair -> pair_cnt=0.
